// File: rtl/lemmings_pkg.sv
// lemmings_pkg: state encoding and counter-width helper shared by the Lemming controller
package lemmings_pkg;
    typedef enum logic [2:0] {
        WALK_L = 3'd0,
        WALK_R = 3'd1,
        FALL_L = 3'd2,
        FALL_R = 3'd3,
        DIG_L  = 3'd4,
        DIG_R  = 3'd5,
        SPLAT  = 3'd6
    } state_t;

    function automatic int cnt_width(input int n);
        return $clog2(n + 1);
    endfunction
endpackage

// File: rtl/lemmings_fall_timer.sv
// lemmings_fall_timer: saturating fall-duration counter, flags when the current aaah cycle exceeds the limit
module lemmings_fall_timer
    import lemmings_pkg::*;
#(
    parameter int SPLAT_CYCLES = 20,
    parameter int CNT_W = cnt_width(SPLAT_CYCLES)
) (
    input  logic clk,
    input  logic areset,
    input  logic count_en,
    output logic limit_hit
);
    localparam logic [CNT_W-1:0] MAX = CNT_W'(SPLAT_CYCLES);
    logic [CNT_W-1:0] cnt;

    always_ff @(posedge clk or posedge areset) begin
        if (areset) cnt <= '0;
        else cnt <= !count_en ? '0 : (cnt == MAX) ? cnt : cnt + CNT_W'(1);
    end

    // cnt+1 is the aaah cycle count including the current one; widened so it cannot overflow
    assign limit_hit = ({1'b0, cnt} + (CNT_W+1)'(1)) > (CNT_W+1)'(SPLAT_CYCLES);
endmodule

// File: rtl/lemmings_dig_splat.sv
// lemmings_dig_splat: Moore controller for a walking, digging, falling Lemming that splatters on long falls
module lemmings_dig_splat
    import lemmings_pkg::*;
#(
    parameter int SPLAT_CYCLES = 20,
    parameter int SPLAT_EN = 1,
    parameter int CNT_W = cnt_width(SPLAT_CYCLES)
) (
    input  logic clk,
    input  logic areset,
    input  logic bump_left,
    input  logic bump_right,
    input  logic ground,
    input  logic dig,
    output logic walk_left,
    output logic walk_right,
    output logic aaah,
    output logic digging,
    output logic splat
);
    state_t state, next;
    logic limit_hit;

    lemmings_fall_timer #(.SPLAT_CYCLES(SPLAT_CYCLES), .CNT_W(CNT_W)) u_timer (
        .clk(clk),
        .areset(areset),
        .count_en(aaah),
        .limit_hit(limit_hit)
    );

    always_ff @(posedge clk or posedge areset) begin
        if (areset) state <= WALK_L;
        else state <= next;
    end

    always_comb begin
        next = state;
        case (state)
            WALK_L: next = !ground ? FALL_L : dig ? DIG_L : bump_left ? WALK_R : WALK_L;
            WALK_R: next = !ground ? FALL_R : dig ? DIG_R : bump_right ? WALK_L : WALK_R;
            FALL_L: next = !ground ? FALL_L : (SPLAT_EN != 0 && limit_hit) ? SPLAT : WALK_L;
            FALL_R: next = !ground ? FALL_R : (SPLAT_EN != 0 && limit_hit) ? SPLAT : WALK_R;
            DIG_L:  next = ground ? DIG_L : FALL_L;
            DIG_R:  next = ground ? DIG_R : FALL_R;
            SPLAT:  next = SPLAT;
            default: next = WALK_L;
        endcase
    end

    assign walk_left  = state == WALK_L;
    assign walk_right = state == WALK_R;
    assign aaah       = state == FALL_L || state == FALL_R;
    assign digging    = state == DIG_L || state == DIG_R;
    assign splat      = state == SPLAT;
endmodule
